tdm_demux16: RTL and testbench

Serial-to-parallel time-division demultiplexer: the receive end of our 16:1 select-driven multiplexer path. The transmitter serialises 16 channels by stepping a 4-bit select 0..15 and emitting one bit per step. This block tracks that select sequence with an internal slot counter and routes each bit back to its lane. It publishes each complete 16-lane frame atomically, and flags framing errors and loss of alignment.

---
 rtl/tdm_demux16.sv | 106 ++++++++++
 tb/tb_tdm_demux16.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux16.sv
// Receive end of the select-driven TDM path: tracks the transmitter's slot sequence,
// gathers one bit per slot into a shadow frame and publishes complete frames atomically.
module tdm_demux16 #(
    parameter int SEL_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  frame_start,
    output logic [(1<<SEL_W)-1:0] dout,
    output logic                  frame_valid,
    output logic [SEL_W-1:0]      slot,
    output logic                  locked,
    output logic                  sync_err,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int               LANES = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(LANES - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t             state, state_nxt;
    logic [LANES-1:0]   shadow, shadow_nxt;
    logic [LANES-1:0]   dout_nxt;
    logic [SEL_W-1:0]   slot_nxt;
    logic [CNT_W-1:0]   frame_cnt_nxt;
    logic               frame_valid_nxt;
    logic               sync_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        shadow_nxt      = shadow;
        dout_nxt        = dout;
        slot_nxt        = slot;
        frame_cnt_nxt   = frame_cnt;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_start) begin
                        shadow_nxt[0] = din;
                        slot_nxt      = SEL_W'(1);
                        state_nxt     = RUN;
                    end
                end
                RUN: begin
                    if (frame_start) begin
                        // An early start abandons the partial frame and restarts at slot 0.
                        sync_err_nxt  = (slot != '0);
                        shadow_nxt[0] = din;
                        slot_nxt      = SEL_W'(1);
                    end else if (slot == '0) begin
                        sync_err_nxt = 1'b1;
                        slot_nxt     = '0;
                        state_nxt    = HUNT;
                    end else begin
                        shadow_nxt[slot] = din;
                        slot_nxt         = slot + 1'b1;
                        if (slot == LAST) begin
                            dout_nxt        = {din, shadow[LANES-2:0]};
                            frame_valid_nxt = 1'b1;
                            frame_cnt_nxt   = frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            dout        <= '0;
            slot        <= '0;
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            shadow      <= shadow_nxt;
            dout        <= dout_nxt;
            slot        <= slot_nxt;
            frame_cnt   <= frame_cnt_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
            locked      <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16: alignment, full-rate and gapped frames, framing
// errors, asynchronous reset and frame counter wrap.
module tb_tdm_demux16;

    localparam int SEL_W = 4;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] dout;
    logic        frame_valid;
    logic [3:0]  slot;
    logic        locked;
    logic        sync_err;
    logic [7:0]  frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int fv_cnt = 0;
    int se_cnt = 0;
    int fv0, se0;
    logic [15:0] w;

    always #5 clk = ~clk;

    tdm_demux16 #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .dout(dout), .frame_valid(frame_valid),
        .slot(slot), .locked(locked), .sync_err(sync_err), .frame_cnt(frame_cnt)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_valid) fv_cnt <= fv_cnt + 1;
        if (sync_err)    se_cnt <= se_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic d, input logic fs);
        @(negedge clk);
        din = d; din_valid = 1'b1; frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b0; frame_start = 1'b0; din = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [15:0] wd, input int first, input int last);
        for (int k = first; k <= last; k++) beat(wd[k], k == 0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 16'h0000);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_slot", slot, 4'd0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_se", sync_err, 1'b0);
        chk("rst_cnt", frame_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Beats without frame_start are discarded in HUNT
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        chk("hunt_locked", locked, 1'b0);
        chk("hunt_slot", slot, 4'd0);
        chk("hunt_se", se_cnt, 0);

        // Single frame at full rate
        frame(16'hA5C3, 0, 0);
        chk("align_locked", locked, 1'b1);
        chk("align_slot", slot, 4'd1);
        frame(16'hA5C3, 1, 14);
        chk("pre_done_dout", dout, 16'h0000);
        frame(16'hA5C3, 15, 15);
        chk("f1_dout", dout, 16'hA5C3);
        chk("f1_fv", frame_valid, 1'b1);
        chk("f1_cnt", frame_cnt, 8'd1);
        chk("f1_slot", slot, 4'd0);
        idle(1);
        chk("f1_fv_drop", frame_valid, 1'b0);
        chk("f1_fv_count", fv_cnt, 1);

        // Gapped frame
        fv0 = fv_cnt; se0 = se_cnt;
        frame(16'hA5C3, 0, 4);
        idle(3);
        chk("gap_slot", slot, 4'd5);
        chk("gap_locked", locked, 1'b1);
        frame(16'hA5C3, 5, 11);
        idle(3);
        frame(16'hA5C3, 12, 15);
        chk("gap_dout", dout, 16'hA5C3);
        chk("gap_cnt", frame_cnt, 8'd2);
        idle(1);
        chk("gap_fv_count", fv_cnt - fv0, 1);
        chk("gap_se_count", se_cnt - se0, 0);

        // Early frame_start at slot 9
        fv0 = fv_cnt; se0 = se_cnt;
        frame(16'hFFFF, 0, 8);
        chk("early_slot", slot, 4'd9);
        chk("early_hold", dout, 16'hA5C3);
        frame(16'h1234, 0, 0);
        chk("early_se", sync_err, 1'b1);
        chk("early_locked", locked, 1'b1);
        chk("early_slot1", slot, 4'd1);
        frame(16'h1234, 1, 14);
        chk("early_pre", dout, 16'hA5C3);
        frame(16'h1234, 15, 15);
        chk("early_dout", dout, 16'h1234);
        chk("early_cnt", frame_cnt, 8'd3);
        idle(1);
        chk("early_se_count", se_cnt - se0, 1);
        chk("early_fv_count", fv_cnt - fv0, 1);

        // Missing frame_start after a complete frame
        beat(1'b1, 1'b0);
        chk("miss_se", sync_err, 1'b1);
        chk("miss_locked", locked, 1'b0);
        chk("miss_slot", slot, 4'd0);
        chk("miss_dout", dout, 16'h1234);
        idle(1);
        chk("miss_se_drop", sync_err, 1'b0);
        frame(16'h0F0F, 0, 0);
        chk("relock", locked, 1'b1);
        frame(16'h0F0F, 1, 15);
        chk("relock_dout", dout, 16'h0F0F);
        chk("relock_cnt", frame_cnt, 8'd4);

        // Asynchronous reset mid-frame
        frame(16'h5A5A, 0, 15);
        chk("pre_rst_cnt", frame_cnt, 8'd5);
        frame(16'hFFFF, 0, 5);
        chk("pre_rst_slot", slot, 4'd6);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", dout, 16'h0000);
        chk("arst_slot", slot, 4'd0);
        chk("arst_locked", locked, 1'b0);
        chk("arst_cnt", frame_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) beat(1'b0, 1'b0);
        chk("arst_hunt_locked", locked, 1'b0);
        chk("arst_hunt_slot", slot, 4'd0);

        // Counter wrap over 256 back-to-back frames
        fv0 = fv_cnt; se0 = se_cnt;
        for (int f = 0; f < 256; f++) begin
            w = {f[7:0], ~f[7:0]};
            frame(w, 0, 15);
            if (f == 254) chk("wrap_cnt_255", frame_cnt, 8'd255);
        end
        chk("wrap_cnt_0", frame_cnt, 8'd0);
        chk("wrap_dout", dout, 16'hFF00);
        idle(1);
        chk("wrap_fv_count", fv_cnt - fv0, 256);
        chk("wrap_se_count", se_cnt - se0, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
